dot_product_row_scheduler: RTL and testbench

Sequencer that drives the 8-lane dot-product unit through a full matrix-vector pass. For each row it fetches element packages from the operand buffer and issues them to the unit with a read-now strobe, waits for the unit's ready and finish, then writes each row result to the result buffer. It sits between the top-level matrix controller (start/done) and one dot-product instance.

---
 rtl/dot_product_row_scheduler_if.sv | 45 ++++
 rtl/dot_product_row_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_dot_product_row_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_row_scheduler_if.sv
// Bus between the matrix controller / operand buffer / dot-product unit / result buffer
// and dot_product_row_scheduler. stall_cycles exists only with DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN.
interface dot_product_row_scheduler_if #(
  parameter int unsigned ELEMENT_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned ROW_WIDTH     = 16
) ();
  logic                     start;
  logic [ROW_WIDTH-1:0]     num_rows;
  logic [31:0]              row_length;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic                     pkg_rd_en;
  logic [ADDR_WIDTH-1:0]    pkg_addr;
  logic                     dp_read_now;
  logic [31:0]              dp_total;
  logic                     dp_ready;
  logic                     dp_finish;
  logic [ELEMENT_WIDTH-1:0] dp_result;
  logic                     res_wr_en;
  logic [ROW_WIDTH-1:0]     res_addr;
  logic [ELEMENT_WIDTH-1:0] res_data;
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
  logic [31:0]              stall_cycles;
`endif

  modport slave (
    input  start, num_rows, row_length, dp_ready, dp_finish, dp_result,
    output busy, done, error, pkg_rd_en, pkg_addr, dp_read_now, dp_total,
           res_wr_en, res_addr, res_data
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport master (
    output start, num_rows, row_length, dp_ready, dp_finish, dp_result,
    input  busy, done, error, pkg_rd_en, pkg_addr, dp_read_now, dp_total,
           res_wr_en, res_addr, res_data
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
    , input stall_cycles
`endif
  );
endinterface

// File: rtl/dot_product_row_scheduler.sv
// Sequences one matrix-vector pass through an 8-lane dot-product unit, row by row.
// Optional stall counter: define DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN.
module dot_product_row_scheduler #(
  parameter int unsigned ELEMENT_WIDTH = 32,
  parameter int unsigned NO_OF_UNITS   = 8,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned ROW_WIDTH     = 16,
  parameter int unsigned TIMEOUT       = 1024
) (
  input logic clk,
  input logic reset,
  dot_product_row_scheduler_if.slave bus
);
  localparam int unsigned UNIT_SHIFT = $clog2(NO_OF_UNITS);
  localparam int unsigned WD_WIDTH   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] UNIT_MASK  = 32'(NO_OF_UNITS - 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_FETCH, S_STROBE, S_WAIT_READY, S_WAIT_FINISH, S_WRITE, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [ROW_WIDTH-1:0]     num_rows_q, num_rows_d;
  logic [31:0]              pkgs_per_row_q, pkgs_per_row_d;
  logic [31:0]              pkg_cnt_q, pkg_cnt_d;
  logic [ROW_WIDTH-1:0]     row_q, row_d;
  logic [WD_WIDTH-1:0]      wd_q, wd_d;
  logic                     fin_prev_q, fin_prev_d;
  logic                     ready_q, ready_d;
  logic                     fin_pend_q, fin_pend_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     pkg_rd_en_q, pkg_rd_en_d;
  logic [ADDR_WIDTH-1:0]    pkg_addr_q, pkg_addr_d;
  logic                     dp_read_now_q, dp_read_now_d;
  logic [31:0]              dp_total_q, dp_total_d;
  logic                     res_wr_en_q, res_wr_en_d;
  logic [ROW_WIDTH-1:0]     res_addr_q, res_addr_d;
  logic [ELEMENT_WIDTH-1:0] res_data_q, res_data_d;
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
  logic [31:0]              stall_q, stall_d;
`endif

  logic                     fin_edge_c;
  logic                     row_length_ok_c;
  logic [31:0]              pkg_cnt_inc_c;
  logic [ROW_WIDTH-1:0]     row_inc_c;
  logic                     wd_expired_c;

  assign fin_edge_c      = bus.dp_finish & ~fin_prev_q;
  assign row_length_ok_c = (bus.row_length != 32'd0) && ((bus.row_length & UNIT_MASK) == 32'd0);
  assign pkg_cnt_inc_c   = pkg_cnt_q + 32'd1;
  assign row_inc_c       = row_q + ROW_WIDTH'(1);
  assign wd_expired_c    = (wd_q == WD_LAST);

  // Next-state and registered-output decode
  always_comb begin
    state_d        = state_q;
    num_rows_d     = num_rows_q;
    pkgs_per_row_d = pkgs_per_row_q;
    pkg_cnt_d      = pkg_cnt_q;
    row_d          = row_q;
    wd_d           = '0;
    fin_prev_d     = bus.dp_finish;
    ready_d        = bus.dp_ready;
    fin_pend_d     = fin_pend_q;
    error_d        = error_q;
    pkg_addr_d     = pkg_addr_q;
    dp_total_d     = dp_total_q;
    res_addr_d     = res_addr_q;
    res_data_d     = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_rows_d     = bus.num_rows;
          pkgs_per_row_d = bus.row_length >> UNIT_SHIFT;
          dp_total_d     = bus.row_length;
          pkg_cnt_d      = '0;
          row_d          = '0;
          pkg_addr_d     = '0;
          fin_pend_d     = 1'b0;
          error_d        = !row_length_ok_c;
          if (!row_length_ok_c || bus.num_rows == '0) state_d = S_DONE;
          else                                         state_d = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_FETCH;
      S_FETCH:  state_d = S_STROBE;
      S_STROBE: state_d = S_WAIT_READY;
      S_WAIT_READY: begin
        wd_d = wd_q + WD_WIDTH'(1);
        // A finish edge racing the last ready is held for WAIT_FINISH
        if (fin_edge_c) fin_pend_d = 1'b1;
        if (ready_q) begin
          pkg_addr_d = pkg_addr_q + ADDR_WIDTH'(1);
          pkg_cnt_d  = pkg_cnt_inc_c;
          wd_d       = '0;
          if (pkg_cnt_inc_c < pkgs_per_row_q) state_d = S_ISSUE;
          else                                state_d = S_WAIT_FINISH;
        end else if (wd_expired_c) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_FINISH: begin
        wd_d = wd_q + WD_WIDTH'(1);
        if (fin_edge_c || fin_pend_q) begin
          res_data_d = bus.dp_result;
          res_addr_d = row_q;
          fin_pend_d = 1'b0;
          state_d    = S_WRITE;
        end else if (wd_expired_c) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        row_d     = row_inc_c;
        pkg_cnt_d = '0;
        if (row_inc_c < num_rows_q) state_d = S_ISSUE;
        else                        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    pkg_rd_en_d   = (state_d == S_ISSUE);
    dp_read_now_d = (state_d == S_STROBE);
    res_wr_en_d   = (state_d == S_WRITE);

`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.start) begin
      stall_d = '0;
    end else if ((state_q == S_WAIT_READY || state_q == S_WAIT_FINISH) && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
`else
    // Stall counter not built in this configuration
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      num_rows_q     <= '0;
      pkgs_per_row_q <= '0;
      pkg_cnt_q      <= '0;
      row_q          <= '0;
      wd_q           <= '0;
      fin_prev_q     <= 1'b0;
      ready_q        <= 1'b0;
      fin_pend_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      pkg_rd_en_q    <= 1'b0;
      pkg_addr_q     <= '0;
      dp_read_now_q  <= 1'b0;
      dp_total_q     <= '0;
      res_wr_en_q    <= 1'b0;
      res_addr_q     <= '0;
      res_data_q     <= '0;
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
      stall_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      num_rows_q     <= num_rows_d;
      pkgs_per_row_q <= pkgs_per_row_d;
      pkg_cnt_q      <= pkg_cnt_d;
      row_q          <= row_d;
      wd_q           <= wd_d;
      fin_prev_q     <= fin_prev_d;
      ready_q        <= ready_d;
      fin_pend_q     <= fin_pend_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      pkg_rd_en_q    <= pkg_rd_en_d;
      pkg_addr_q     <= pkg_addr_d;
      dp_read_now_q  <= dp_read_now_d;
      dp_total_q     <= dp_total_d;
      res_wr_en_q    <= res_wr_en_d;
      res_addr_q     <= res_addr_d;
      res_data_q     <= res_data_d;
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
      stall_q        <= stall_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.pkg_rd_en   = pkg_rd_en_q;
  assign bus.pkg_addr    = pkg_addr_q;
  assign bus.dp_read_now = dp_read_now_q;
  assign bus.dp_total    = dp_total_q;
  assign bus.res_wr_en   = res_wr_en_q;
  assign bus.res_addr    = res_addr_q;
  assign bus.res_data    = res_data_q;
`ifdef DOT_PRODUCT_ROW_SCHEDULER_STALL_CNT_EN
  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_dot_product_row_scheduler.sv
// Directed bench for dot_product_row_scheduler: a simple dot-product responder
// (ready the cycle after each strobe, finish 4 cycles after a row's last ready) plus event logging.
module tb_dot_product_row_scheduler;
  localparam int unsigned EW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned RW = 16;
  localparam int unsigned TO = 16;
  localparam logic [31:0] RES_BASE = 32'hA5C0_0000;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dot_product_row_scheduler_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)) bus ();

  dot_product_row_scheduler #(
    .ELEMENT_WIDTH(EW), .NO_OF_UNITS(8), .ADDR_WIDTH(AW), .ROW_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  t0;
  iq_t rd_addr, rd_cyc, wr_addr, wr_data, wr_cyc, done_cyc, rn_cyc;
  bit  ready_auto, fin_en, fin_sticky, rn_last;
  int  fin_cnt, pk, ppr, row_tb;
  logic b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input iq_t got, input iq_t exp);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  function automatic iq_t rel(input iq_t q);
    iq_t r;
    foreach (q[i]) r.push_back(q[i] - t0);
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 32'({bus.busy, bus.done, bus.error, bus.pkg_rd_en,
                                bus.dp_read_now, bus.res_wr_en}), 32'd0);
    check({tag, "_pkg_addr"}, 32'(bus.pkg_addr), 32'd0);
    check({tag, "_dp_total"}, bus.dp_total, 32'd0);
    check({tag, "_res_addr"}, 32'(bus.res_addr), 32'd0);
    check({tag, "_res_data"}, bus.res_data, 32'd0);
  endtask

  // One clock: log this cycle's outputs, then act as the dot-product unit
  task automatic tick();
    bit new_ready;
    @(posedge clk); #1;
    cyc++;
    if (bus.pkg_rd_en)   begin rd_addr.push_back(int'(bus.pkg_addr)); rd_cyc.push_back(cyc); end
    if (bus.res_wr_en)   begin
      wr_addr.push_back(int'(bus.res_addr)); wr_data.push_back(int'(bus.res_data)); wr_cyc.push_back(cyc);
    end
    if (bus.done)        done_cyc.push_back(cyc);
    if (bus.dp_read_now) rn_cyc.push_back(cyc);
    if (fin_sticky && bus.dp_ready)      bus.dp_finish = 1'b0;
    else if (!fin_sticky && fin_cnt == 0) bus.dp_finish = 1'b0;
    new_ready = ready_auto && rn_last;
    rn_last   = bus.dp_read_now;
    if (fin_cnt != 0) begin
      fin_cnt--;
      if (fin_cnt == 0) begin
        bus.dp_finish = 1'b1;
        bus.dp_result = RES_BASE + 32'(row_tb);
        row_tb++;
      end
    end
    bus.dp_ready = new_ready;
    if (new_ready) begin
      pk++;
      if (pk >= ppr) begin
        pk = 0;
        if (fin_en) fin_cnt = 4;
      end
    end
  endtask

  task automatic clear_log();
    rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_data.delete();
    wr_cyc.delete(); done_cyc.delete(); rn_cyc.delete();
    pk = 0; row_tb = 0; fin_cnt = 0; rn_last = 0;
  endtask

  task automatic start_pass(input int rows, input int rl);
    clear_log();
    ppr = rl / 8;
    bus.num_rows   = RW'(rows);
    bus.row_length = 32'(rl);
    bus.start      = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    b1 = bus.busy;
  endtask

  task automatic run_pass(input int rows, input int rl, input int budget, input bit mid_start);
    start_pass(rows, rl);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) begin
      bus.start = mid_start && (i == 3);
      if (mid_start && i == 3) bus.num_rows = RW'(7);
      tick();
    end
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.num_rows = '0; bus.row_length = '0;
    bus.dp_ready = 1'b0; bus.dp_finish = 1'b0; bus.dp_result = '0;
    ready_auto = 1'b1; fin_en = 1'b1; fin_sticky = 1'b0;
    clear_log();
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Two rows of two packages, plus a start while busy that must be ignored
    run_pass(2, 16, 80, 1'b1);
    check("t1_busy_t1", 32'(b1), 32'd1);
    check_q("t1_rn_cyc", rel(rn_cyc[0:0]), {3});
    check_q("t1_rd_addr", rd_addr, {0, 1, 2, 3});
    check_q("t1_rd_cyc", rel(rd_cyc), {1, 6, 15, 20});
    check_q("t1_wr_addr", wr_addr, {0, 1});
    check_q("t1_wr_data", wr_data, {int'(RES_BASE), int'(RES_BASE + 32'd1)});
    check_q("t1_wr_cyc", rel(wr_cyc), {14, 28});
    check_q("t1_done_cyc", rel(done_cyc), {29});
    check("t1_error", 32'(bus.error), 32'd0);
    check("t1_busy_after", 32'(bus.busy), 32'd0);
    check("t1_dp_total", bus.dp_total, 32'd16);

    // Row length not a multiple of 8
    run_pass(2, 12, 10, 1'b0);
    check("t2_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("t2_done_within_2", 32'((done_cyc[0] - t0) <= 2), 32'd1);
    check("t2_error", 32'(bus.error), 32'd1);
    check("t2_rd_count", 32'(rd_addr.size()), 32'd0);

    // Zero rows with a valid length: clean empty pass, clears previous error
    run_pass(0, 8, 10, 1'b0);
    check("t3_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("t3_done_within_2", 32'((done_cyc[0] - t0) <= 2), 32'd1);
    check("t3_error", 32'(bus.error), 32'd0);
    check("t3_wr_count", 32'(wr_addr.size()), 32'd0);
    check("t3_rd_count", 32'(rd_addr.size()), 32'd0);

    // Unit never ready: watchdog fires 16 cycles after entering WAIT_READY
    ready_auto = 1'b0;
    run_pass(1, 8, 40, 1'b0);
    check_q("t4_done_cyc", rel(done_cyc), {20});
    check("t4_error", 32'(bus.error), 32'd1);
    check("t4_rd_count", 32'(rd_addr.size()), 32'd0 + 32'd1);
    check("t4_wr_count", 32'(wr_addr.size()), 32'd0);
    ready_auto = 1'b1;

    // Sticky finish level, dropped only after the next row's ready
    fin_sticky = 1'b1;
    run_pass(3, 8, 60, 1'b0);
    check_q("t5_wr_addr", wr_addr, {0, 1, 2});
    check_q("t5_wr_data", wr_data, {int'(RES_BASE), int'(RES_BASE + 32'd1), int'(RES_BASE + 32'd2)});
    check_q("t5_wr_cyc", rel(wr_cyc), {9, 18, 27});
    check_q("t5_done_cyc", rel(done_cyc), {28});
    check("t5_error", 32'(bus.error), 32'd0);
    fin_sticky = 1'b0;
    bus.dp_finish = 1'b0;
    tick();

    // Reset while waiting for finish, then a clean pass from address 0
    fin_en = 1'b0;
    start_pass(1, 8);
    while (cyc - t0 < 7) tick();
    check("t6_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    check_zero("t6_reset");
    check("t6_wr_count", 32'(wr_addr.size()), 32'd0);
    reset = 1'b0;
    fin_en = 1'b1;
    tick();
    run_pass(2, 8, 60, 1'b0);
    check_q("t6_rd_addr", rd_addr, {0, 1});
    check_q("t6_wr_data", wr_data, {int'(RES_BASE), int'(RES_BASE + 32'd1)});
    check_q("t6_done_cyc", rel(done_cyc), {19});
    check("t6_error", 32'(bus.error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
